source_controller: RTL and testbench
====================================

# source_controller

Source-side controller of the AHB2AHB bridge. Runs in the source clock domain opposite the sink controller. Packs transfers from the source-side slave interface into request packets for the request FIFO, and unpacks response packets from the response FIFO into read data. Owns the source half of the sleep handshake: it drains in-flight traffic before reporting sleep status to the sink side.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- packet_width, 66, request packet width = ADDR_WIDTH+DATA_WIDTH+2
- MAX_OUTSTANDING, 4, maximum reads accepted but not yet answered (1..15)

Ports:
- i_clk_source  in  1  source clock; the block's only clock
- i_rstn_source  in  1  asynchronous, active-low reset
- i_source_sleep_req  in  1  local sleep request
- sink_sleep_status  in  1  sink-side sleep status (already synchronised)
- i_valid  in  1  slave-side transfer request
- i_rd0_wr1  in  1  0 = read, 1 = write
- i_addr  in  ADDR_WIDTH  transfer address
- i_wr_data  in  DATA_WIDTH  write data
- o_ready  out  1  transfer accepted when high together with i_valid
- o_rd_data  out  DATA_WIDTH  read data
- o_rd_valid  out  1  one-cycle read-data strobe
- req_fifo_full  in  1  request FIFO full
- req_fifo_empty  in  1  request FIFO empty (synchronised from the sink side)
- req_fifo_wr_en  out  1  push o_packet
- o_packet  out  packet_width  {rd0_wr1, valid, addr, wr_data}
- rsp_fifo_empty  in  1  response FIFO empty
- i_packet  in  DATA_WIDTH+1  show-ahead response head {rd_valid, rd_data}
- rsp_fifo_rd_en  out  1  pop response
- o_source_sleep_ack  out  1  sleep acknowledge
- source_sleep_status  out  1  source side is asleep
- o_rsp_err  out  1  one-cycle pulse on an unexpected response

## Operation
- States: NORMAL, DRAIN, IDLE. Encoding is shared with the sink controller: 00 = NORMAL, 01 = DRAIN, 11 = IDLE. Reset state is NORMAL.
- NORMAL → DRAIN when i_source_sleep_req or sink_sleep_status is high.
- DRAIN → IDLE when outstanding == 0, req_fifo_empty is high, and rsp_fifo_empty is high.
- DRAIN → NORMAL when both i_source_sleep_req and sink_sleep_status are low. This check takes priority over DRAIN → IDLE.
- IDLE → NORMAL when both i_source_sleep_req and sink_sleep_status are low.
- o_ready is high only in NORMAL, with req_fifo_full low, and not (i_rd0_wr1 == 0 and outstanding == MAX_OUTSTANDING).
- Accept = i_valid & o_ready. On accept:
  - req_fifo_wr_en = 1.
  - o_packet = {i_rd0_wr1, 1'b1, i_addr, wdata}, where wdata = i_wr_data for writes and 0 for reads.
  - When there is no accept, o_packet = 0.
- Outstanding counter is $clog2(MAX_OUTSTANDING+1) bits wide:
  - +1 on an accepted read.
  - −1 when a popped response has rd_valid = 1.
  - Both events in the same cycle: the counter is unchanged.
- Response path:
  - rsp_fifo_rd_en = !rsp_fifo_empty in NORMAL and DRAIN; 0 in IDLE.
  - A popped packet with rd_valid = 1 and outstanding > 0 produces o_rd_data/o_rd_valid.
  - rd_valid = 0: the packet is discarded silently.
  - rd_valid = 1 with outstanding == 0: the packet is discarded, o_rsp_err pulses, and the counter stays at 0.
- source_sleep_status = (state == IDLE).
- o_source_sleep_ack = (state == IDLE) & i_source_sleep_req.
- Writes get no response; write completion is the FIFO push.

## Timing
- Reset values: state NORMAL, outstanding 0, and every registered output (o_rd_data, o_rd_valid, o_rsp_err) 0. The combinational outputs evaluate to 0 while reset is asserted.
- Request latency is zero: req_fifo_wr_en is combinational in the accept cycle.
- o_ready depends combinationally on i_rd0_wr1 through the read limit.
- Response latency is one cycle: o_rd_data, o_rd_valid and o_rsp_err are registered and appear the cycle after rsp_fifo_rd_en.
- Sustained throughput is one request per cycle and one response per cycle.
- State transitions take effect on the clock edge. o_ready drops in the first DRAIN cycle.
- Reset mid-operation: the counter clears, pending o_rd_valid is dropped, and FIFO contents are the FIFOs' responsibility.

## Structure
- Shared package bridge_pkg holds:
  - state encodings,
  - packet field offsets (RW_BIT = packet_width−1, VALID_BIT = packet_width−2),
  - response valid bit = DATA_WIDTH.
  The sink controller uses the same package.
- One natural sub-module, outstanding_tracker: the up/down counter, with the full flag and the zero flag.

## Test plan
- **Write pass-through:** i_valid=1, i_rd0_wr1=1, addr 0x1000, data 0xDEADBEEF, FIFO not full → same cycle req_fifo_wr_en=1, o_packet = {1,1,0x00001000,0xDEADBEEF}.
- **Read limit:** 4 reads accepted with no responses → o_ready=0 for a 5th read, o_ready=1 for a write. Push response {1,0x12345678} → o_rd_valid=1 with 0x12345678 one cycle after the pop; the counter goes 4→3 and the read is accepted again.
- **Back-pressure:** req_fifo_full=1 with i_valid=1 → o_ready=0 and req_fifo_wr_en=0 every cycle until full drops.
- **Sleep drain:** 2 reads outstanding, then i_source_sleep_req=1 → DRAIN, o_ready=0. After both responses and with both FIFOs empty → IDLE, source_sleep_status=1, o_source_sleep_ack=1. Release the request → NORMAL.
- **Unexpected response:** response {1,0xA5A5A5A5} with outstanding 0 → o_rsp_err pulses 1 cycle, o_rd_valid stays 0, counter stays 0.
- **Reset mid-traffic:** assert i_rstn_source low while 3 reads are outstanding and a response is being popped → all outputs 0, counter 0, state NORMAL after release.

Source files
------------

// File: rtl/bridge_pkg.sv
// bridge_pkg: shared AHB2AHB bridge encodings for the source and sink controllers.
// Holds the controller state encoding and the bit offsets of the request and
// response packet fields.
package bridge_pkg;
  typedef enum logic [1:0] {
    ST_NORMAL = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_IDLE   = 2'b11
  } state_e;
  function automatic int rw_bit(input int pw);
    return pw - 1;
  endfunction
  function automatic int valid_bit(input int pw);
    return pw - 2;
  endfunction
  function automatic int rsp_valid_bit(input int dw);
    return dw;
  endfunction
endpackage

// File: rtl/outstanding_tracker.sv
// outstanding_tracker: up/down count of reads accepted but not yet answered.
// Ports: clk/rst_n (async active-low), inc/dec events, full (count == MAX),
// zero (count == 0). Simultaneous inc and dec leave the count unchanged.
module outstanding_tracker #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    count_d = count_q + CW'(inc & ~dec) - CW'(dec & ~inc);
    full    = count_q == CW'(MAX_OUTSTANDING);
    zero    = count_q == '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
endmodule

// File: rtl/source_controller.sv
// source_controller: source-side AHB2AHB bridge controller.
// Packs accepted slave transfers into request packets (zero latency), unpacks
// response packets into registered read data (one cycle), and drains in-flight
// traffic before reporting sleep to the sink side.
// Ports: slave side (i_valid/i_rd0_wr1/i_addr/i_wr_data/o_ready/o_rd_*),
// request FIFO push side, response FIFO pop side, sleep handshake, o_rsp_err.
module source_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int packet_width    = ADDR_WIDTH + DATA_WIDTH + 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    i_clk_source,
  input  logic                    i_rstn_source,
  input  logic                    i_source_sleep_req,
  input  logic                    sink_sleep_status,
  input  logic                    i_valid,
  input  logic                    i_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  output logic                    o_ready,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_valid,
  input  logic                    req_fifo_full,
  input  logic                    req_fifo_empty,
  output logic                    req_fifo_wr_en,
  output logic [packet_width-1:0] o_packet,
  input  logic                    rsp_fifo_empty,
  input  logic [DATA_WIDTH:0]     i_packet,
  output logic                    rsp_fifo_rd_en,
  output logic                    o_source_sleep_ack,
  output logic                    source_sleep_status,
  output logic                    o_rsp_err
);
  localparam int RW_BIT    = rw_bit(packet_width);
  localparam int VALID_BIT = valid_bit(packet_width);
  localparam int RSP_VALID = rsp_valid_bit(DATA_WIDTH);
  state_e state_q, state_d;
  logic cnt_full, cnt_zero, sleepy, drained, accept, rsp_v, dec;
  logic rd_valid_q, rd_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [packet_width-1:0] pkt;
  outstanding_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_tracker (
    .clk  (i_clk_source),
    .rst_n(i_rstn_source),
    .inc  (accept & ~i_rd0_wr1),
    .dec  (dec),
    .full (cnt_full),
    .zero (cnt_zero)
  );
  always_comb begin
    sleepy  = i_source_sleep_req | sink_sleep_status;
    drained = cnt_zero & req_fifo_empty & rsp_fifo_empty;
    // Release of both sleep sources wins over completing the drain; the
    // unused encoding 2'b10 falls back into DRAIN.
    state_d = !sleepy ? ST_NORMAL :
              (state_q == ST_NORMAL) ? ST_DRAIN :
              (state_q == ST_IDLE || drained) ? ST_IDLE : ST_DRAIN;
    // Combinational outputs are forced low while reset is held.
    o_ready = i_rstn_source & (state_q == ST_NORMAL) & ~req_fifo_full & ~(~i_rd0_wr1 & cnt_full);
    accept  = i_valid & o_ready;
    pkt = '0;
    pkt[RW_BIT] = i_rd0_wr1;
    pkt[VALID_BIT] = 1'b1;
    pkt[VALID_BIT-1 -: ADDR_WIDTH] = i_addr;
    pkt[DATA_WIDTH-1:0] = i_wr_data & {DATA_WIDTH{i_rd0_wr1}};
    o_packet       = accept ? pkt : '0;
    req_fifo_wr_en = accept;
    rsp_fifo_rd_en = i_rstn_source & (state_q != ST_IDLE) & ~rsp_fifo_empty;
    rsp_v      = rsp_fifo_rd_en & i_packet[RSP_VALID];
    dec        = rsp_v & ~cnt_zero;
    rd_valid_d = dec;
    rsp_err_d  = rsp_v & cnt_zero;
    rd_data_d  = dec ? i_packet[DATA_WIDTH-1:0] : rd_data_q;
    source_sleep_status = state_q == ST_IDLE;
    o_source_sleep_ack  = (state_q == ST_IDLE) & i_source_sleep_req;
    o_rd_valid = rd_valid_q;
    o_rd_data  = rd_data_q;
    o_rsp_err  = rsp_err_q;
  end
  always_ff @(posedge i_clk_source or negedge i_rstn_source)
    if (!i_rstn_source) begin
      state_q    <= ST_NORMAL;
      rd_valid_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rsp_err_q  <= rsp_err_d;
      rd_data_q  <= rd_data_d;
    end
endmodule

// File: tb/tb_source_controller.sv
// tb_source_controller: directed vector table, corner sequences and random
// traffic against a behavioural model of the source controller.
module tb_source_controller;
  localparam int MAXO = 4;
  logic clk = 1'b0;
  logic rstn, sreq, ssts, valid, rw, full, req_empty, rempty;
  logic [31:0] addr, wd;
  logic [32:0] ipkt;
  logic o_ready, o_rd_valid, req_fifo_wr_en, rsp_fifo_rd_en, ack, status, o_rsp_err;
  logic [31:0] o_rd_data;
  logic [65:0] o_packet;
  int checks = 0, passes = 0;
  int m_out, m_mode;
  logic m_rdv, m_err;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  source_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .packet_width(66), .MAX_OUTSTANDING(MAXO)) dut (
    .i_clk_source(clk), .i_rstn_source(rstn), .i_source_sleep_req(sreq), .sink_sleep_status(ssts),
    .i_valid(valid), .i_rd0_wr1(rw), .i_addr(addr), .i_wr_data(wd), .o_ready(o_ready),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .req_fifo_full(full), .req_fifo_empty(req_empty),
    .req_fifo_wr_en(req_fifo_wr_en), .o_packet(o_packet), .rsp_fifo_empty(rempty), .i_packet(ipkt),
    .rsp_fifo_rd_en(rsp_fifo_rd_en), .o_source_sleep_ack(ack), .source_sleep_status(status),
    .o_rsp_err(o_rsp_err)
  );

  typedef struct {
    logic v, rw;
    logic [31:0] a, d;
    logic full, remp;
    logic [32:0] ip;
    logic e_rdy, e_wr;
    logic [65:0] e_pkt;
    logic e_rdv;
    logic [31:0] e_rd;
  } vec_t;
  vec_t tbl[14];

  function automatic vec_t mk(input logic v, input logic r, input logic [31:0] a, input logic [31:0] d,
                              input logic f, input logic re, input logic [32:0] ip, input logic er,
                              input logic ew, input logic [65:0] ep, input logic ev, input logic [31:0] ed);
    vec_t t;
    t.v = v; t.rw = r; t.a = a; t.d = d; t.full = f; t.remp = re; t.ip = ip;
    t.e_rdy = er; t.e_wr = ew; t.e_pkt = ep; t.e_rdv = ev; t.e_rd = ed;
    return t;
  endfunction

  function automatic logic [65:0] pk(input logic r, input logic [31:0] a, input logic [31:0] d);
    return {r, 1'b1, a, d};
  endfunction

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) $display("FAIL %s: got %b want %b", n, a, e);
    else passes++;
  endtask

  task automatic chkw(input string n, input logic [65:0] a, input logic [65:0] e);
    checks++;
    if (a !== e) $display("FAIL %s: got %h want %h", n, a, e);
    else passes++;
  endtask

  // Model: mode 0 = normal, 1 = draining, 2 = asleep; m_out counts unanswered reads.
  task automatic model_check();
    logic rdy, acc, pop, v, dec;
    logic [65:0] pkt;
    if (!rstn) begin
      m_out = 0; m_mode = 0; m_rdv = 1'b0; m_err = 1'b0; m_rdata = '0;
    end
    rdy = rstn && m_mode == 0 && !full && !(!rw && m_out == MAXO);
    acc = valid && rdy;
    pkt = acc ? {rw, 1'b1, addr, rw ? wd : 32'h0} : 66'h0;
    pop = rstn && m_mode != 2 && !rempty;
    chk1("ready", o_ready, rdy);
    chk1("wr_en", req_fifo_wr_en, acc);
    chkw("packet", o_packet, pkt);
    chk1("rd_en", rsp_fifo_rd_en, pop);
    chk1("status", status, m_mode == 2);
    chk1("ack", ack, m_mode == 2 && sreq);
    chk1("rd_valid", o_rd_valid, m_rdv);
    chk1("rsp_err", o_rsp_err, m_err);
    if (m_rdv) chkw("rd_data", 66'(o_rd_data), 66'(m_rdata));
    if (rstn) begin
      v = pop && ipkt[32];
      dec = v && m_out > 0;
      if (!(sreq || ssts)) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1 && m_out == 0 && req_empty && rempty) m_mode = 2;
      m_err = v && m_out == 0;
      m_rdv = dec;
      if (dec) m_rdata = ipkt[31:0];
      m_out = m_out + ((acc && !rw) ? 1 : 0) - (dec ? 1 : 0);
    end
  endtask

  task automatic tick();
    #1 model_check();
  endtask

  initial begin
    rstn = 1'b0; sreq = 1'b0; ssts = 1'b0; valid = 1'b0; rw = 1'b0; full = 1'b0;
    req_empty = 1'b1; rempty = 1'b1; addr = '0; wd = '0; ipkt = '0;
    tbl[0]  = mk(1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 1'b0, 1'b1, 33'h0, 1'b1, 1'b1, pk(1'b1, 32'h1000, 32'hDEADBEEF), 1'b0, 32'h0);
    tbl[1]  = mk(1'b1, 1'b0, 32'h10, 32'hFFFFFFFF, 1'b0, 1'b1, 33'h0, 1'b1, 1'b1, pk(1'b0, 32'h10, 32'h0), 1'b0, 32'h0);
    tbl[2]  = mk(1'b1, 1'b0, 32'h20, 32'hFFFFFFFF, 1'b0, 1'b1, 33'h0, 1'b1, 1'b1, pk(1'b0, 32'h20, 32'h0), 1'b0, 32'h0);
    tbl[3]  = mk(1'b1, 1'b0, 32'h30, 32'hFFFFFFFF, 1'b0, 1'b1, 33'h0, 1'b1, 1'b1, pk(1'b0, 32'h30, 32'h0), 1'b0, 32'h0);
    tbl[4]  = mk(1'b1, 1'b0, 32'h40, 32'hFFFFFFFF, 1'b0, 1'b1, 33'h0, 1'b1, 1'b1, pk(1'b0, 32'h40, 32'h0), 1'b0, 32'h0);
    tbl[5]  = mk(1'b1, 1'b0, 32'h50, 32'hFFFFFFFF, 1'b0, 1'b1, 33'h0, 1'b0, 1'b0, 66'h0, 1'b0, 32'h0);
    tbl[6]  = mk(1'b1, 1'b1, 32'h60, 32'h11, 1'b0, 1'b1, 33'h0, 1'b1, 1'b1, pk(1'b1, 32'h60, 32'h11), 1'b0, 32'h0);
    tbl[7]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, {1'b1, 32'h12345678}, 1'b0, 1'b0, 66'h0, 1'b0, 32'h0);
    tbl[8]  = mk(1'b1, 1'b0, 32'h80, 32'hFFFFFFFF, 1'b0, 1'b1, 33'h0, 1'b1, 1'b1, pk(1'b0, 32'h80, 32'h0), 1'b1, 32'h12345678);
    tbl[9]  = mk(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, {1'b1, 32'hA5A5A5A5}, 1'b1, 1'b0, 66'h0, 1'b0, 32'h0);
    tbl[10] = mk(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 33'h0, 1'b1, 1'b0, 66'h0, 1'b1, 32'hA5A5A5A5);
    tbl[11] = mk(1'b1, 1'b1, 32'h90, 32'h1, 1'b1, 1'b1, 33'h0, 1'b0, 1'b0, 66'h0, 1'b0, 32'h0);
    tbl[12] = mk(1'b1, 1'b0, 32'h94, 32'h1, 1'b1, 1'b1, 33'h0, 1'b0, 1'b0, 66'h0, 1'b0, 32'h0);
    tbl[13] = mk(1'b1, 1'b1, 32'h99, 32'h77, 1'b0, 1'b1, 33'h0, 1'b1, 1'b1, pk(1'b1, 32'h99, 32'h77), 1'b0, 32'h0);
    @(negedge clk);
    valid = 1'b1; rempty = 1'b0; ipkt = {1'b1, 32'h1};
    tick();
    chk1("reset_ready", o_ready, 1'b0);
    chk1("reset_rd_en", rsp_fifo_rd_en, 1'b0);
    @(negedge clk);
    rstn = 1'b1; valid = 1'b0; rempty = 1'b1; ipkt = '0;
    tick();
    @(negedge clk);
    foreach (tbl[i]) begin
      valid = tbl[i].v; rw = tbl[i].rw; addr = tbl[i].a; wd = tbl[i].d;
      full = tbl[i].full; rempty = tbl[i].remp; ipkt = tbl[i].ip;
      #1;
      chk1($sformatf("vec%0d_ready", i), o_ready, tbl[i].e_rdy);
      chk1($sformatf("vec%0d_wr_en", i), req_fifo_wr_en, tbl[i].e_wr);
      chkw($sformatf("vec%0d_packet", i), o_packet, tbl[i].e_pkt);
      chk1($sformatf("vec%0d_rd_valid", i), o_rd_valid, tbl[i].e_rdv);
      if (tbl[i].e_rdv) chkw($sformatf("vec%0d_rd_data", i), 66'(o_rd_data), 66'(tbl[i].e_rd));
      model_check();
      @(negedge clk);
    end
    // Reset while three reads are outstanding and a response is being popped.
    valid = 1'b0; full = 1'b0; rempty = 1'b0; ipkt = {1'b1, 32'hCAFE0001};
    tick();
    chk1("mid_pop_rd_en", rsp_fifo_rd_en, 1'b1);
    @(negedge clk);
    rstn = 1'b0; valid = 1'b1; rw = 1'b1;
    tick();
    chk1("rst_rd_valid", o_rd_valid, 1'b0);
    chk1("rst_wr_en", req_fifo_wr_en, 1'b0);
    chk1("rst_rd_en", rsp_fifo_rd_en, 1'b0);
    @(negedge clk);
    rstn = 1'b1; valid = 1'b0; rempty = 1'b1; ipkt = '0;
    tick();
    chk1("post_rst_ready", o_ready, 1'b1);
    chk1("post_rst_status", status, 1'b0);
    // Unexpected response with nothing outstanding.
    @(negedge clk);
    rempty = 1'b0; ipkt = {1'b1, 32'hA5A5A5A5};
    tick();
    @(negedge clk);
    rempty = 1'b1; ipkt = '0;
    tick();
    chk1("unexp_err", o_rsp_err, 1'b1);
    chk1("unexp_rd_valid", o_rd_valid, 1'b0);
    @(negedge clk);
    tick();
    chk1("unexp_err_pulse", o_rsp_err, 1'b0);
    // Sleep drain with two reads outstanding.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      valid = 1'b1; rw = 1'b0; addr = 32'h200 + 32'(k);
      tick();
    end
    @(negedge clk);
    valid = 1'b0; sreq = 1'b1;
    tick();
    @(negedge clk);
    valid = 1'b1; rempty = 1'b0; ipkt = {1'b1, 32'h0000BEE1};
    tick();
    chk1("drain_ready", o_ready, 1'b0);
    @(negedge clk);
    valid = 1'b0; ipkt = {1'b1, 32'h0000BEE2};
    tick();
    @(negedge clk);
    rempty = 1'b1; ipkt = '0; req_empty = 1'b1;
    tick();
    chk1("drain_not_yet_idle", status, 1'b0);
    @(negedge clk);
    tick();
    chk1("idle_status", status, 1'b1);
    chk1("idle_ack", ack, 1'b1);
    @(negedge clk);
    sreq = 1'b0;
    tick();
    @(negedge clk);
    valid = 1'b1; rw = 1'b1;
    tick();
    chk1("wake_status", status, 1'b0);
    chk1("wake_ready", o_ready, 1'b1);
    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      valid = $urandom_range(3) != 0;
      rw = 1'($urandom);
      addr = $urandom; wd = $urandom;
      full = $urandom_range(3) == 0;
      req_empty = $urandom_range(2) != 0;
      rempty = 1'($urandom);
      ipkt = {$urandom_range(9) < 7, 32'($urandom)};
      if ($urandom_range(39) == 0) sreq = ~sreq;
      if ($urandom_range(59) == 0) ssts = ~ssts;
      rstn = $urandom_range(499) != 0;
      tick();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
